// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE array and its psum collector.
package pe_array_pkg;

    localparam int NUM_COLS = 14;
    localparam int PE_ROWS  = 12;
    localparam int DATA_W   = 16;
    localparam int DEPTH    = 64;
    localparam int ADDR_W   = 6;
    localparam int PIX_W    = ADDR_W + 1;
    localparam int LANE_W   = 4;

    typedef logic [15:0] psum_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } coll_state_t;

    // Pixel count per pass: 0 behaves as 1, anything above DEPTH saturates.
    function automatic logic [PIX_W-1:0] clamp_pix(input logic [PIX_W-1:0] n);
        if (n == '0)
            return PIX_W'(1);
        else if (n > PIX_W'(DEPTH))
            return PIX_W'(DEPTH);
        else
            return n;
    endfunction

    // Lane/column counts live in 1..NUM_COLS; keep the counters in range.
    function automatic logic [LANE_W-1:0] clamp_lane(input logic [LANE_W-1:0] v);
        if (v == '0)
            return LANE_W'(1);
        else if (v > LANE_W'(NUM_COLS))
            return LANE_W'(NUM_COLS);
        else
            return v;
    endfunction

endpackage

// File: rtl/psum_group_reduce.sv
// Combinational grouping adder: lane p sums columns p*Q .. p*Q+Q-1.
// Columns past the array edge add nothing; lanes p >= P read as zero.
module psum_group_reduce
    import pe_array_pkg::*;
(
    input  logic [LANE_W-1:0]          p_lanes,
    input  logic [LANE_W-1:0]          q_cols,
    input  logic [NUM_COLS*DATA_W-1:0] psum_in,
    output logic [NUM_COLS*DATA_W-1:0] lane_sum
);

    psum_t col [NUM_COLS];

    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
            assign col[gi] = psum_in[gi*DATA_W +: DATA_W];
        end

        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_lane
            psum_t acc;

            // Sum the Q columns that belong to this lane, wrapping at DATA_W.
            always_comb begin
                int idx;
                acc = '0;
                for (int k = 0; k < NUM_COLS; k++) begin
                    idx = gi * int'(q_cols) + k;
                    if (k < int'(q_cols) && idx < NUM_COLS)
                        acc = acc + col[idx[3:0]];
                end
                if (gi >= int'(p_lanes))
                    acc = '0;
            end

            assign lane_sum[gi*DATA_W +: DATA_W] = acc;
        end
    endgenerate

endmodule

// File: rtl/psum_collector.sv
// Collects bottom-row psums from the PE array, reduces columns into filter
// lanes, accumulates across passes in a local ofmap buffer and drains the
// result as a pixel-major valid/ready stream after the last pass.
module psum_collector
    import pe_array_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANE_W-1:0]          P,
    input  logic [LANE_W-1:0]          Q,
    input  logic [ADDR_W:0]            num_pix,
    input  logic                       pass_start,
    input  logic                       first_pass,
    input  logic                       last_pass,
    input  logic [NUM_COLS*DATA_W-1:0] psum_in,
    input  logic                       psum_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [LANE_W-1:0]          out_filt,
    output logic [ADDR_W-1:0]          out_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       pass_complete,
    output logic                       overflow
);

    coll_state_t               state_reg;
    logic [LANE_W-1:0]         p_reg;
    logic [LANE_W-1:0]         q_reg;
    logic [PIX_W-1:0]          npix_reg;
    logic                      first_reg;
    logic                      last_reg;
    logic [PIX_W-1:0]          beat_cnt_reg;
    logic                      wr_pending_reg;
    logic [ADDR_W-1:0]         wr_addr_reg;
    logic [ADDR_W-1:0]         cur_addr_reg;
    logic [LANE_W-1:0]         cur_filt_reg;
    logic                      drain_more_reg;
    logic [DATA_W-1:0]         out_data_reg;
    logic [LANE_W-1:0]         out_filt_reg;
    logic [ADDR_W-1:0]         out_addr_reg;
    logic                      out_valid_reg;
    logic                      busy_reg;
    logic                      pass_complete_reg;
    logic                      overflow_reg;

    // Datapath storage, not reset.
    logic [NUM_COLS*DATA_W-1:0] mem [DEPTH];
    logic [NUM_COLS*DATA_W-1:0] lane_sum_reg;
    logic [NUM_COLS*DATA_W-1:0] rd_row_reg;

    logic [NUM_COLS*DATA_W-1:0] lane_sum;
    logic [NUM_COLS*DATA_W-1:0] wr_row;
    psum_t                      rd_lane [NUM_COLS];

    logic                start_ok;
    logic                beat_accept;
    logic [ADDR_W-1:0]   beat_addr;
    logic [LANE_W-1:0]   p_sel;
    logic [LANE_W-1:0]   q_sel;
    logic                accum_done;
    logic                drain_load;
    logic                last_filt;
    logic                last_elem;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;

    // A beat coincident with pass_start is beat 0 and uses the live P/Q.
    assign start_ok    = (state_reg == IDLE) && pass_start;
    assign beat_accept = psum_valid &&
                         (start_ok || ((state_reg == ACCUM) && (beat_cnt_reg < npix_reg)));
    assign beat_addr   = start_ok ? '0 : beat_cnt_reg[ADDR_W-1:0];
    assign p_sel       = start_ok ? clamp_lane(P) : p_reg;
    assign q_sel       = start_ok ? clamp_lane(Q) : q_reg;

    // All beats counted and the last buffer write has landed.
    assign accum_done  = (state_reg == ACCUM) && (beat_cnt_reg == npix_reg) && !wr_pending_reg;
    assign drain_load  = (state_reg == DRAIN) && drain_more_reg && (!out_valid_reg || out_ready);
    assign last_filt   = (cur_filt_reg == p_reg - LANE_W'(1));
    assign last_elem   = last_filt && ({1'b0, cur_addr_reg} == npix_reg - PIX_W'(1));

    psum_group_reduce u_reduce (
        .p_lanes  (p_sel),
        .q_cols   (q_sel),
        .psum_in  (psum_in),
        .lane_sum (lane_sum)
    );

    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_row
            assign wr_row[gi*DATA_W +: DATA_W] =
                first_reg ? lane_sum_reg[gi*DATA_W +: DATA_W]
                          : rd_row_reg[gi*DATA_W +: DATA_W] + lane_sum_reg[gi*DATA_W +: DATA_W];
            assign rd_lane[gi] = rd_row_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Single read port: beat rows for accumulate, then drain rows. Row 0 is
    // prefetched on the ACCUM->DRAIN edge so the first word is ready at once.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if (beat_accept) begin
            rd_en   = 1'b1;
            rd_addr = beat_addr;
        end else if (accum_done && last_reg) begin
            rd_en   = 1'b1;
            rd_addr = '0;
        end else if (drain_load && last_filt) begin
            rd_en   = 1'b1;
            rd_addr = cur_addr_reg + ADDR_W'(1);
        end
    end

    // Buffer RAM with registered read, plus the reduction pipeline register.
    always_ff @(posedge clk) begin
        if (beat_accept)
            lane_sum_reg <= lane_sum;
        if (wr_pending_reg)
            mem[wr_addr_reg] <= wr_row;
        if (rd_en)
            rd_row_reg <= mem[rd_addr];
    end

    // Control FSM with registered status and stream outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            p_reg             <= LANE_W'(1);
            q_reg             <= LANE_W'(1);
            npix_reg          <= PIX_W'(1);
            first_reg         <= 1'b1;
            last_reg          <= 1'b0;
            beat_cnt_reg      <= '0;
            wr_pending_reg    <= 1'b0;
            wr_addr_reg       <= '0;
            cur_addr_reg      <= '0;
            cur_filt_reg      <= '0;
            drain_more_reg    <= 1'b0;
            out_data_reg      <= '0;
            out_filt_reg      <= '0;
            out_addr_reg      <= '0;
            out_valid_reg     <= 1'b0;
            busy_reg          <= 1'b0;
            pass_complete_reg <= 1'b0;
            overflow_reg      <= 1'b0;
        end else begin
            pass_complete_reg <= 1'b0;
            wr_pending_reg    <= beat_accept;
            if (beat_accept)
                wr_addr_reg <= beat_addr;
            if (psum_valid && !beat_accept)
                overflow_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (pass_start) begin
                        p_reg        <= clamp_lane(P);
                        q_reg        <= clamp_lane(Q);
                        npix_reg     <= clamp_pix(num_pix);
                        first_reg    <= first_pass;
                        last_reg     <= last_pass;
                        beat_cnt_reg <= psum_valid ? PIX_W'(1) : '0;
                        state_reg    <= ACCUM;
                        busy_reg     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (beat_accept) begin
                        beat_cnt_reg <= beat_cnt_reg + PIX_W'(1);
                    end else if (accum_done) begin
                        if (last_reg) begin
                            state_reg      <= DRAIN;
                            cur_addr_reg   <= '0;
                            cur_filt_reg   <= '0;
                            drain_more_reg <= 1'b1;
                        end else begin
                            state_reg         <= DONE;
                            pass_complete_reg <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_load) begin
                        out_data_reg  <= rd_lane[cur_filt_reg];
                        out_filt_reg  <= cur_filt_reg;
                        out_addr_reg  <= cur_addr_reg;
                        out_valid_reg <= 1'b1;
                        if (last_filt) begin
                            cur_filt_reg <= '0;
                            cur_addr_reg <= cur_addr_reg + ADDR_W'(1);
                        end else begin
                            cur_filt_reg <= cur_filt_reg + LANE_W'(1);
                        end
                        if (last_elem)
                            drain_more_reg <= 1'b0;
                    end else if (out_valid_reg && out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (!drain_more_reg) begin
                            state_reg         <= DONE;
                            pass_complete_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data      = out_data_reg;
    assign out_filt      = out_filt_reg;
    assign out_addr      = out_addr_reg;
    assign out_valid     = out_valid_reg;
    assign busy          = busy_reg;
    assign pass_complete = pass_complete_reg;
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: vector table of single passes plus
// hand-written multi-pass, overflow and reset sequences.
module tb_psum_collector;
    import pe_array_pkg::*;

    typedef logic [NUM_COLS-1:0][DATA_W-1:0] row_t;

    typedef struct {
        logic [3:0] p;
        logic [3:0] q;
        logic [6:0] np;
        int         eff;
        bit         cobeat;
        bit         stall;
        psum_t      bstep;
        row_t       cols;
        row_t       exp;
    } vec_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [3:0]                 P, Q;
    logic [ADDR_W:0]            num_pix;
    logic                       pass_start, first_pass, last_pass;
    logic [NUM_COLS*DATA_W-1:0] psum_in;
    logic                       psum_valid;
    logic [DATA_W-1:0]          out_data;
    logic [3:0]                 out_filt;
    logic [ADDR_W-1:0]          out_addr;
    logic                       out_valid, out_ready, busy, pass_complete, overflow;

    int tests_run = 0;
    int tests_failed = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    psum_collector dut (
        .clk           (clk),
        .rst           (rst),
        .P             (P),
        .Q             (Q),
        .num_pix       (num_pix),
        .pass_start    (pass_start),
        .first_pass    (first_pass),
        .last_pass     (last_pass),
        .psum_in       (psum_in),
        .psum_valid    (psum_valid),
        .out_data      (out_data),
        .out_filt      (out_filt),
        .out_addr      (out_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .pass_complete (pass_complete),
        .overflow      (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic row_t row_const(input psum_t v);
        row_t r;
        for (int c = 0; c < NUM_COLS; c++) r[c] = v;
        return r;
    endfunction

    function automatic row_t row_ramp();
        row_t r;
        for (int c = 0; c < NUM_COLS; c++) r[c] = psum_t'(c + 1);
        return r;
    endfunction

    function automatic logic [NUM_COLS*DATA_W-1:0] mk_beat(input row_t cols, input psum_t bstep, input int b);
        logic [NUM_COLS*DATA_W-1:0] v;
        for (int c = 0; c < NUM_COLS; c++) v[c*DATA_W +: DATA_W] = cols[c] + psum_t'(b) * bstep;
        return v;
    endfunction

    // Start a pass and stream nbeats beats (beat b: each column + b*bstep).
    task automatic send_pass(input logic [3:0] p, input logic [3:0] q, input logic [6:0] np,
                             input bit first, input bit last, input bit cobeat, input int nbeats,
                             input row_t cols, input psum_t bstep);
        int b;
        b = 0;
        @(negedge clk);
        P = p; Q = q; num_pix = np; first_pass = first; last_pass = last;
        pass_start = 1'b1; psum_valid = 1'b0;
        if (cobeat && nbeats > 0) begin
            psum_in = mk_beat(cols, bstep, 0);
            psum_valid = 1'b1;
            b = 1;
        end
        while (b < nbeats) begin
            @(negedge clk);
            pass_start = 1'b0;
            psum_in = mk_beat(cols, bstep, b);
            psum_valid = 1'b1;
            b++;
        end
        @(negedge clk);
        pass_start = 1'b0;
        psum_valid = 1'b0;
        $display("[TB] pass P=%0d Q=%0d num_pix=%0d first=%0b last=%0b beats=%0d", p, q, np, first, last, nbeats);
    endtask

    // Collect the drain stream; element k is (addr k/p, filt k%p).
    task automatic drain_check(input string tag, input logic [3:0] p, input int npix,
                               input row_t exp, input psum_t astep, input bit stall);
        int k, cyc, a;
        bit done, held;
        logic [3:0] pat, f;
        logic [DATA_W-1:0] hd;
        logic [3:0] hf;
        logic [ADDR_W-1:0] ha;
        k = 0; cyc = 0; done = 0; held = 0; pat = 4'b1001;
        hd = '0; hf = '0; ha = '0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            if (held) begin
                chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_stall_data"}, 32'(out_data), 32'(hd));
                chk({tag, "_stall_filt"}, 32'(out_filt), 32'(hf));
                chk({tag, "_stall_addr"}, 32'(out_addr), 32'(ha));
            end
            out_ready = stall ? pat[cyc[1:0]] : 1'b1;
            held = out_valid && !out_ready;
            hd = out_data; hf = out_filt; ha = out_addr;
            if (out_valid && out_ready) begin
                f = 4'(k % int'(p));
                a = k / int'(p);
                $display("[TB] %s xfer #%0d addr=%0d filt=%0d data=0x%04h", tag, k, out_addr, out_filt, out_data);
                chk({tag, "_data"}, 32'(out_data), 32'(exp[f] + psum_t'(a) * astep));
                chk({tag, "_filt"}, 32'(out_filt), 32'(f));
                chk({tag, "_addr"}, 32'(out_addr), 32'(a));
                k++;
            end
            if (pass_complete) done = 1;
            cyc++;
        end
        out_ready = 1'b1;
        chk({tag, "_complete_seen"}, 32'(done), 32'd1);
        chk({tag, "_count"}, 32'(k), 32'(int'(p) * npix));
        @(negedge clk);
        chk({tag, "_complete_pulse"}, 32'(pass_complete), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    // Non-last pass: expect pass_complete and no drain activity.
    task automatic wait_complete(input string tag);
        int cyc;
        bit seen, bad;
        cyc = 0; seen = 0; bad = 0;
        while (!seen && cyc < 500) begin
            @(negedge clk);
            if (out_valid) bad = 1;
            if (pass_complete) seen = 1;
            cyc++;
        end
        $display("[TB] %s pass_complete after %0d cycles", tag, cyc);
        chk({tag, "_complete_seen"}, 32'(seen), 32'd1);
        chk({tag, "_no_valid"}, 32'(bad), 32'd0);
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        row_t r;
        int cyc;

        // ---- vector table ----
        vecs[0] = '{p: 4'd2, q: 4'd7, np: 7'd4, eff: 4, cobeat: 0, stall: 0, bstep: 16'd0,
                    cols: row_const(16'd1), exp: row_const(16'd7)};
        vecs[1] = '{p: 4'd14, q: 4'd1, np: 7'd2, eff: 2, cobeat: 1, stall: 1, bstep: 16'd1,
                    cols: row_ramp(), exp: row_ramp()};
        vecs[2] = '{p: 4'd3, q: 4'd4, np: 7'd3, eff: 3, cobeat: 0, stall: 1, bstep: 16'd1,
                    cols: row_ramp(), exp: row_const(16'd0)};
        vecs[2].exp[0] = 16'd10; vecs[2].exp[1] = 16'd26; vecs[2].exp[2] = 16'd42;
        vecs[3] = '{p: 4'd1, q: 4'd14, np: 7'd0, eff: 1, cobeat: 1, stall: 0, bstep: 16'd1,
                    cols: row_ramp(), exp: row_const(16'd0)};
        vecs[3].exp[0] = 16'd105;
        vecs[4] = '{p: 4'd7, q: 4'd2, np: 7'd1, eff: 1, cobeat: 0, stall: 1, bstep: 16'd1,
                    cols: row_const(16'hFFFF), exp: row_const(16'hFFFE)};
        vecs[5] = '{p: 4'd1, q: 4'd1, np: 7'd70, eff: 64, cobeat: 0, stall: 0, bstep: 16'd1,
                    cols: row_const(16'd5), exp: row_const(16'd5)};

        rst = 1'b1; P = '0; Q = '0; num_pix = '0; pass_start = 0; first_pass = 0; last_pass = 0;
        psum_in = '0; psum_valid = 0; out_ready = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pass_complete", 32'(pass_complete), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_filt", 32'(out_filt), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send_pass(vecs[i].p, vecs[i].q, vecs[i].np, 1'b1, 1'b1, vecs[i].cobeat, vecs[i].eff,
                      vecs[i].cols, vecs[i].bstep);
            drain_check($sformatf("vec%0d", i), vecs[i].p, vecs[i].eff, vecs[i].exp,
                        psum_t'(vecs[i].q) * vecs[i].bstep, vecs[i].stall);
        end
        chk("table_overflow_clear", 32'(overflow), 32'd0);

        // ---- three accumulating passes, P=14 Q=1 ----
        send_pass(4'd14, 4'd1, 7'd3, 1'b1, 1'b0, 1'b0, 3, row_ramp(), 16'd0);
        wait_complete("multi_p1");
        send_pass(4'd14, 4'd1, 7'd3, 1'b0, 1'b0, 1'b0, 3, row_ramp(), 16'd0);
        wait_complete("multi_p2");
        send_pass(4'd14, 4'd1, 7'd3, 1'b0, 1'b1, 1'b0, 3, row_ramp(), 16'd0);
        for (int c = 0; c < NUM_COLS; c++) r[c] = psum_t'(3 * (c + 1));
        drain_check("multi_p3", 4'd14, 3, r, 16'd0, 1'b0);

        // ---- modulo wrap across two passes ----
        r = row_const(16'd0); r[0] = 16'h8000; r[1] = 16'h8001;
        send_pass(4'd1, 4'd2, 7'd1, 1'b1, 1'b0, 1'b0, 1, r, 16'd0);
        wait_complete("wrap_p1");
        send_pass(4'd1, 4'd2, 7'd1, 1'b0, 1'b1, 1'b0, 1, r, 16'd0);
        r = row_const(16'd0); r[0] = 16'h0002;
        drain_check("wrap_p2", 4'd1, 1, r, 16'd0, 1'b0);

        // ---- extra beat, then a beat in IDLE ----
        chk("ovf_before", 32'(overflow), 32'd0);
        r = row_const(16'd0); r[0] = 16'd10;
        send_pass(4'd1, 4'd1, 7'd2, 1'b1, 1'b1, 1'b0, 3, r, 16'd1);
        drain_check("ovf_pass", 4'd1, 2, r, 16'd1, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        @(negedge clk); psum_valid = 1'b1;
        @(negedge clk); psum_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovf_held", 32'(overflow), 32'd1);
        chk("ovf_idle_busy", 32'(busy), 32'd0);

        // ---- asynchronous reset while draining ----
        out_ready = 1'b0;
        send_pass(4'd2, 4'd1, 7'd4, 1'b1, 1'b1, 1'b0, 4, row_ramp(), 16'd0);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rstmid_valid_before", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        r = row_const(16'd0); r[0] = 16'h1234;
        send_pass(4'd1, 4'd1, 7'd1, 1'b1, 1'b1, 1'b0, 1, r, 16'd0);
        drain_check("post_rst", 4'd1, 1, r, 16'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sits directly downstream of the 12x14 weight-stationary PE array and consumes the 14 bottom-row psum outputs.
- Reduces each group of Q adjacent columns into one psum per filter lane (P lanes).
- Accumulates those psums across channel/filter-element passes in a local ofmap buffer.
- After the last pass, drains results serially over a valid/ready stream to the ofmap writeback.

Parameters:
- NUM_COLS, 14, PE array columns (psum inputs).
- DATA_W, 16, psum width; all arithmetic is two's-complement, modulo 2^DATA_W.
- DEPTH, 64, ofmap pixels per pass held in the buffer.
- ADDR_W, 6, log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- P  in  4  filter lanes in use (1..14).
- Q  in  4  columns per lane (1..14); legal when P*Q <= 14.
- num_pix  in  ADDR_W+1  psum beats (pixels) per pass, 1..DEPTH.
- pass_start  in  1  one-cycle pulse that starts a pass.
- first_pass  in  1  sampled at pass_start; 1 = overwrite buffer, 0 = accumulate.
- last_pass  in  1  sampled at pass_start; 1 = drain after accumulate.
- psum_in  in  NUM_COLS*DATA_W  column psums; column c is at bits [c*16+:16].
- psum_valid  in  1  psum_in holds one pixel beat.
- out_data  out  DATA_W  drained psum.
- out_filt  out  4  lane index of out_data.
- out_addr  out  ADDR_W  pixel index of out_data.
- out_valid  out  1  out_data, out_filt, out_addr valid.
- out_ready  in  1  consumer accepts.
- busy  out  1  FSM not IDLE.
- pass_complete  out  1  one-cycle pulse at the end of each pass (after drain, when draining).
- overflow  out  1  sticky: a beat arrived when not expected; cleared only by reset.

Behaviour:
- Reset values: out_valid, busy, pass_complete and overflow are 0; out_data, out_filt and out_addr are 0; FSM is IDLE. Buffer contents are not reset.
- FSM states:
  - IDLE: on pass_start, latch P, Q, num_pix, first_pass and last_pass; clear beat and write counters; go to ACCUM.
  - ACCUM: count accepted beats. When the beat count equals num_pix and the pipeline has flushed, go to DRAIN if last_pass, else go to DONE.
  - DRAIN: emit results ordered pixel-major, then filter lane: (addr 0, filt 0..P-1), (addr 1, ...), up to addr num_pix-1. After the final handshake, go to DONE.
  - DONE: pulse pass_complete for one cycle, then go to IDLE.
- Reduction stage (1 cycle): lane p = sum of columns p*Q .. p*Q+Q-1, DATA_W-wide, wrapping. Columns at index >= 14 contribute 0. Lanes p >= P are don't-care and are never drained.
- Buffer stage: on the cycle after a beat, entry[addr] lane p is written with lane_sum when first_pass, otherwise with entry + lane_sum (wrapping). addr increments per beat, so there is no read-modify-write hazard.
- Latency: a beat at cycle t is visible in the buffer at cycle t+2.
- Drain handshake:
  - out_valid rises the cycle after entry to DRAIN.
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
  - A transfer occurs when valid&ready; the next element is presented in the following cycle, giving full throughput of 1 per cycle.
- Boundary conditions:
  - psum_valid in IDLE, DRAIN or DONE, or beyond num_pix beats in ACCUM: beat dropped, overflow set.
  - pass_start while busy: ignored, with no effect on state.
  - pass_start and psum_valid in the same cycle from IDLE: that beat is counted as beat 0.
  - num_pix=0: treated as 1 beat (minimum).
  - num_pix > DEPTH: clamped to DEPTH.
  - Async reset mid-ACCUM or mid-DRAIN: out_valid=0 immediately, FSM to IDLE, partial buffer contents undefined.
  - A new pass must start with first_pass=1.

Decomposition:
- Shared package pe_array_pkg holds:
  - NUM_COLS, PE_ROWS (12), DATA_W.
  - typedef psum_t (logic [15:0]).
  - typedef coll_state_t enum {IDLE, ACCUM, DRAIN, DONE}.
- One sub-module, psum_group_reduce: combinational grouping adder with P and Q inputs, 14 psums in, 14 lane sums out, with the register stage in the parent.

Test Plan:
- P=2, Q=7, num_pix=4, first_pass=1, last_pass=1, all columns = 1 each beat -> drain emits 8 words, all 7, in order (0,0),(0,1),(1,0)..(3,1), then pass_complete pulses.
- Three passes, first_pass only on pass 1, last_pass on pass 3, P=14, Q=1, column c = c+1 -> every lane p drains 3*(p+1); no out_valid during passes 1-2.
- Drain with out_ready toggling 1,0,0,1 each cycle -> fields stable while stalled, no element lost or duplicated; element count = P*num_pix.
- Wrap: P=1, Q=2, columns 0x8000 and 0x8001, two accumulate passes -> result 0x0002 (modulo 2^16).
- num_pix=2 with a 3rd beat sent, then psum_valid in IDLE -> 3rd beat not accumulated; overflow=1 and held until reset.
- Reset (rst=0) asserted mid-DRAIN while out_valid=1 -> out_valid=0 and busy=0 asynchronously; after release, a fresh P=1, Q=1, num_pix=1 pass drains the correct single value.
